uart_interfaz_ctrl: RTL and testbench

//  UART line engine between the UART data register pair and the pins. Serialises the TX byte (data reg 0, low byte) onto tx_o.

---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_interfaz_ctrl_if.sv | 24 ++
 rtl/uart_baud_cnt.sv | 30 +++
 rtl/uart_interfaz_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_uart_interfaz_ctrl.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART line engine.
// Optional feature macro: UART_PARITY_EN (adds the even-parity states).
package uart_pkg;

    localparam int UART_BAUD_DIV_DEF = 87;
    localparam int UART_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef UART_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP,
        TX_DONE
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP,
        RX_WRITE
    } rx_state_t;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_interfaz_ctrl_if.sv
// Register-side bundle between the UART control/data registers and the line engine.
// master = register block, slave = line engine.
interface uart_interfaz_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              send_i;
    logic [7:0]        tx_data_i;
    logic              send_clr_o;
    logic [DATA_W-1:0] rx_data_o;
    logic              rx_wr_o;
    logic              hold_ctrl_o;
    logic              new_rx_o;
    logic              rx_err_o;

    modport master (
        output send_i, tx_data_i,
        input  send_clr_o, rx_data_o, rx_wr_o, hold_ctrl_o, new_rx_o, rx_err_o
    );

    modport slave (
        input  send_i, tx_data_i,
        output send_clr_o, rx_data_o, rx_wr_o, hold_ctrl_o, new_rx_o, rx_err_o
    );
endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..BAUD_DIV-1 (or 0..BAUD_DIV/2-1 when half_sel
// is high) and pulses bit_tick on the last count, wrapping to 0 at that tick.
module uart_baud_cnt #(
    parameter int BAUD_DIV = 87
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear,
    input  logic half_sel,
    output logic bit_tick
);
    localparam int CNT_W = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);

    logic [CNT_W-1:0] cnt_reg;

    assign bit_tick = !clear && (cnt_reg == (half_sel ? HALF_LAST : FULL_LAST));

    // Count within the bit period; restart at each bit boundary or on clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_reg <= '0;
        end else if (clear || bit_tick) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end
endmodule

// File: rtl/uart_interfaz_ctrl.sv
// UART line engine: serialises the TX byte onto tx_o and deserialises rx_i
// into data register 1 through the write-priority (hold) path. 8N1 frames;
// defining UART_PARITY_EN adds an even-parity bit on both directions.
module uart_interfaz_ctrl
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = UART_BAUD_DIV_DEF,
    parameter int DATA_W   = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    uart_interfaz_ctrl_if.slave  bus,
    output logic                 tx_o,
    input  logic                 rx_i
);
    // ---------------- TX ----------------
    tx_state_t  tx_state_reg, tx_state_next;
    logic [7:0] tx_shift_reg;
    logic [2:0] tx_bit_reg;
    logic       tx_guard_reg;   // blocks a stale send_i in the cycle after DONE
    logic       tx_tick;
    logic       tx_start;
`ifdef UART_PARITY_EN
    logic       tx_par_reg;
`endif

    assign tx_start = (tx_state_reg == TX_IDLE) && bus.send_i && !tx_guard_reg;

    uart_baud_cnt #(.BAUD_DIV(BAUD_DIV)) u_tx_baud (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear    ((tx_state_reg == TX_IDLE) || (tx_state_reg == TX_DONE)),
        .half_sel (1'b0),
        .bit_tick (tx_tick)
    );

    // TX state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) tx_state_reg <= TX_IDLE;
        else         tx_state_reg <= tx_state_next;
    end

    // TX next state, line level and completion pulse.
    always_comb begin
        tx_state_next  = tx_state_reg;
        tx_o           = 1'b1;
        bus.send_clr_o = 1'b0;
        case (tx_state_reg)
            TX_IDLE:  if (tx_start) tx_state_next = TX_START;
            TX_START: begin
                tx_o = 1'b0;
                if (tx_tick) tx_state_next = TX_DATA;
            end
            TX_DATA: begin
                tx_o = tx_shift_reg[0];
                if (tx_tick && tx_bit_reg == 3'd7) begin
`ifdef UART_PARITY_EN
                    tx_state_next = TX_PARITY;
`else
                    tx_state_next = TX_STOP;
`endif
                end
            end
`ifdef UART_PARITY_EN
            TX_PARITY: begin
                tx_o = tx_par_reg;
                if (tx_tick) tx_state_next = TX_STOP;
            end
`endif
            TX_STOP:  if (tx_tick) tx_state_next = TX_DONE;
            TX_DONE: begin
                bus.send_clr_o = 1'b1;
                tx_state_next  = TX_IDLE;
            end
            default:  tx_state_next = TX_IDLE;
        endcase
    end

    // TX datapath: latch the byte at frame start, shift out LSB first.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tx_shift_reg <= '0;
            tx_bit_reg   <= '0;
            tx_guard_reg <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par_reg   <= 1'b0;
`endif
        end else begin
            tx_guard_reg <= (tx_state_reg == TX_DONE);
            if (tx_start) begin
                tx_shift_reg <= bus.tx_data_i;
`ifdef UART_PARITY_EN
                tx_par_reg   <= even_parity(bus.tx_data_i);
`endif
            end else if (tx_state_reg == TX_DATA && tx_tick) begin
                tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
            end
            if (tx_state_reg != TX_DATA) tx_bit_reg <= '0;
            else if (tx_tick)            tx_bit_reg <= tx_bit_reg + 3'd1;
        end
    end

    // ---------------- RX ----------------
    rx_state_t         rx_state_reg, rx_state_next;
    logic              rx_sync1_reg, rx_sync2_reg, rx_prev_reg;
    logic [7:0]        rx_shift_reg;
    logic [2:0]        rx_bit_reg;
    logic [DATA_W-1:0] rx_data_reg;
    logic              rx_err_reg;
    logic              rx_tick;
    logic              rx_par_bad;
    logic              rx_stop_fail;
    logic              rx_write;

`ifdef UART_PARITY_EN
    logic rx_par_err_reg;
    assign rx_par_bad = rx_par_err_reg;
`else
    assign rx_par_bad = 1'b0;
`endif

    assign rx_stop_fail = (rx_state_reg == RX_STOP) && rx_tick && (!rx_sync2_reg || rx_par_bad);

    uart_baud_cnt #(.BAUD_DIV(BAUD_DIV)) u_rx_baud (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clear    ((rx_state_reg == RX_IDLE) || (rx_state_reg == RX_WRITE)),
        .half_sel (rx_state_reg == RX_START),
        .bit_tick (rx_tick)
    );

    // RX state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rx_state_reg <= RX_IDLE;
        else         rx_state_reg <= rx_state_next;
    end

    // RX next state; a start sample of 1 is a glitch and returns silently.
    always_comb begin
        rx_state_next = rx_state_reg;
        rx_write      = 1'b0;
        case (rx_state_reg)
            RX_IDLE:  if (rx_prev_reg && !rx_sync2_reg) rx_state_next = RX_START;
            RX_START: if (rx_tick) rx_state_next = rx_sync2_reg ? RX_IDLE : RX_DATA;
            RX_DATA: begin
                if (rx_tick && rx_bit_reg == 3'd7) begin
`ifdef UART_PARITY_EN
                    rx_state_next = RX_PARITY;
`else
                    rx_state_next = RX_STOP;
`endif
                end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: if (rx_tick) rx_state_next = RX_STOP;
`endif
            RX_STOP:  if (rx_tick) rx_state_next = rx_stop_fail ? RX_IDLE : RX_WRITE;
            RX_WRITE: begin
                rx_write      = 1'b1;
                rx_state_next = RX_IDLE;
            end
            default:  rx_state_next = RX_IDLE;
        endcase
    end

    // RX datapath: synchroniser, shift-in LSB first, output byte and error pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_sync1_reg <= 1'b1;
            rx_sync2_reg <= 1'b1;
            rx_prev_reg  <= 1'b1;
            rx_shift_reg <= '0;
            rx_bit_reg   <= '0;
            rx_data_reg  <= '0;
            rx_err_reg   <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_err_reg <= 1'b0;
`endif
        end else begin
            rx_sync1_reg <= rx_i;
            rx_sync2_reg <= rx_sync1_reg;
            rx_prev_reg  <= rx_sync2_reg;
            rx_err_reg   <= rx_stop_fail;
            if (rx_state_reg == RX_DATA && rx_tick)
                rx_shift_reg <= {rx_sync2_reg, rx_shift_reg[7:1]};
            if (rx_state_reg != RX_DATA) rx_bit_reg <= '0;
            else if (rx_tick)            rx_bit_reg <= rx_bit_reg + 3'd1;
            if (rx_state_reg == RX_STOP && rx_tick && !rx_stop_fail)
                rx_data_reg <= DATA_W'(rx_shift_reg);
`ifdef UART_PARITY_EN
            if (rx_state_reg == RX_IDLE)
                rx_par_err_reg <= 1'b0;
            else if (rx_state_reg == RX_PARITY && rx_tick)
                rx_par_err_reg <= rx_sync2_reg ^ even_parity(rx_shift_reg);
`endif
        end
    end

    assign bus.rx_data_o   = rx_data_reg;
    assign bus.rx_wr_o     = rx_write;
    assign bus.hold_ctrl_o = rx_write;
    assign bus.new_rx_o    = rx_write;
    assign bus.rx_err_o    = rx_err_reg;
endmodule

// File: tb/tb_uart_interfaz_ctrl.sv
// Scoreboard bench for uart_interfaz_ctrl: stimulus pushes expectations into
// queues, independent monitors pop and compare when the DUT presents output.
module tb_uart_interfaz_ctrl;
    localparam int BAUD   = 87;
    localparam int DATA_W = 32;
`ifdef UART_PARITY_EN
    localparam int NPAR = 1;
`else
    localparam int NPAR = 0;
`endif
    localparam int NBITS = 10 + NPAR;
    localparam int FRAME = NBITS * BAUD;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx    = 1'b1;
    logic tx;
    int   cyc   = 0;

    uart_interfaz_ctrl_if #(.DATA_W(DATA_W)) bus ();

    uart_interfaz_ctrl #(.BAUD_DIV(BAUD), .DATA_W(DATA_W)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus),
        .tx_o   (tx),
        .rx_i   (rx)
    );

    always #50 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    int n_wr_seen  = 0;
    int n_err_seen = 0;
    int n_clr_seen = 0;
    bit tx_mon_en  = 1'b0;

    logic [31:0] exp_rx_q[$];
    logic [31:0] exp_err_q[$];
    int          exp_clr_q[$];
    logic [7:0]  exp_tx_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: %h (cycle %0d)", name, act, cyc);
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic stop_bit);
`ifdef UART_PARITY_EN
        return {stop_bit, ^b, b, 1'b0};
`else
        return {1'b0, stop_bit, b, 1'b0};
`endif
    endfunction

    task automatic drive_bits(input logic [10:0] bits);
        for (int i = 0; i < NBITS; i++) begin
            rx = bits[i];
            repeat (BAUD) @(negedge clk);
        end
        rx = 1'b1;
        repeat (BAUD) @(negedge clk);
    endtask

    task automatic tx_send(input logic [7:0] b, input bit hold);
        int k;
        @(negedge clk);
        bus.tx_data_i = b;
        bus.send_i    = 1'b1;
        exp_tx_q.push_back(b);
        exp_clr_q.push_back(cyc + 1 + FRAME);
        @(negedge clk);
        bus.tx_data_i = ~b;
        if (!hold) bus.send_i = 1'b0;
        k = 0;
        while (bus.send_clr_o !== 1'b1 && k < FRAME + 50) begin
            @(negedge clk);
            k++;
        end
        check("send_clr_seen", {31'b0, bus.send_clr_o}, 32'd1);
        if (hold) begin
            @(negedge clk);   // send_i still high while the guard is active
            bus.send_i = 1'b0;
        end
    endtask

    // Monitor: RX write strobes and data.
    always @(negedge clk) begin
        if (rst_n && (bus.rx_wr_o | bus.hold_ctrl_o | bus.new_rx_o)) begin
            n_wr_seen++;
            check("rx_wr", {31'b0, bus.rx_wr_o}, 32'd1);
            check("rx_hold", {31'b0, bus.hold_ctrl_o}, 32'd1);
            check("rx_new", {31'b0, bus.new_rx_o}, 32'd1);
            if (exp_rx_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL rx_unexpected_write: got %h, required no write", bus.rx_data_o);
            end else begin
                check("rx_data", bus.rx_data_o, exp_rx_q.pop_front());
            end
        end
    end

    // Monitor: RX error pulses; rx_data_o must still hold the previous byte.
    always @(negedge clk) begin
        if (rst_n && bus.rx_err_o) begin
            n_err_seen++;
            if (exp_err_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL rx_unexpected_err: got rx_err_o=1, required 0");
            end else begin
                check("rx_err_data_kept", bus.rx_data_o, exp_err_q.pop_front());
            end
        end
    end

    // Monitor: TX completion pulse timing.
    always @(negedge clk) begin
        if (rst_n && bus.send_clr_o) begin
            n_clr_seen++;
            if (exp_clr_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL tx_unexpected_clr: got send_clr_o=1 at %0d, required 0", cyc);
            end else begin
                check("send_clr_cycle", cyc, exp_clr_q.pop_front());
            end
        end
    end

    // Monitor: decode frames on tx_o by mid-bit sampling.
    logic [7:0] tx_mon_byte;
    always begin
        @(negedge clk);
        if (tx_mon_en && tx === 1'b0) begin
            repeat (BAUD / 2) @(negedge clk);
            check("tx_start_bit", {31'b0, tx}, 32'd0);
            for (int i = 0; i < 8; i++) begin
                repeat (BAUD) @(negedge clk);
                tx_mon_byte[i] = tx;
            end
`ifdef UART_PARITY_EN
            repeat (BAUD) @(negedge clk);
            check("tx_parity_bit", {31'b0, tx}, {31'b0, ^tx_mon_byte});
`endif
            repeat (BAUD) @(negedge clk);
            check("tx_stop_bit", {31'b0, tx}, 32'd1);
            if (exp_tx_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL tx_unexpected_frame: got %h, required no frame", tx_mon_byte);
            end else begin
                check("tx_byte", {24'b0, tx_mon_byte}, {24'b0, exp_tx_q.pop_front()});
            end
        end
    end

    // Watchdog.
    initial begin
        #(30000 * 100);
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.send_i    = 1'b0;
        bus.tx_data_i = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_tx_o", {31'b0, tx}, 32'd1);
        check("rst_send_clr", {31'b0, bus.send_clr_o}, 32'd0);
        check("rst_rx_wr", {31'b0, bus.rx_wr_o}, 32'd0);
        check("rst_hold", {31'b0, bus.hold_ctrl_o}, 32'd0);
        check("rst_new_rx", {31'b0, bus.new_rx_o}, 32'd0);
        check("rst_rx_err", {31'b0, bus.rx_err_o}, 32'd0);
        check("rst_rx_data", bus.rx_data_o, 32'h0);
        rst_n = 1'b1;

        // Reset in the middle of a TX frame.
        repeat (2) @(negedge clk);
        bus.tx_data_i = 8'h12;
        bus.send_i    = 1'b1;
        @(negedge clk);
        bus.send_i = 1'b0;
        repeat (300) @(negedge clk);   // inside data bit 2 of 8'h12 (=0)
        check("midframe_tx_low", {31'b0, tx}, 32'd0);
        #10 rst_n = 1'b0;
        #1;
        check("async_rst_tx_o", {31'b0, tx}, 32'd1);
        check("async_rst_send_clr", {31'b0, bus.send_clr_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (BAUD) @(negedge clk);
        check("post_rst_idle_tx", {31'b0, tx}, 32'd1);
        tx_mon_en = 1'b1;

        // TX 8'hA5 with send_i held until the completion pulse.
        tx_send(8'hA5, 1'b1);
        repeat (BAUD) @(negedge clk);

        // RX good frame 8'h3C.
        exp_rx_q.push_back(32'h0000003C);
        drive_bits(mk_frame(8'h3C, 1'b1));
        repeat (20) @(negedge clk);

        // RX 8'h55 with a bad stop bit.
        exp_err_q.push_back(32'h0000003C);
        drive_bits(mk_frame(8'h55, 1'b0));
        repeat (20) @(negedge clk);
        check("rx_data_after_err", bus.rx_data_o, 32'h0000003C);

        // 20-cycle low glitch.
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (300) @(negedge clk);
        check("glitch_wr_count", n_wr_seen, 32'd1);
        check("glitch_err_count", n_err_seen, 32'd1);

        // Full duplex: TX 8'hFF (send_i dropped mid-frame) with RX 8'h81 13 cycles later.
        exp_rx_q.push_back(32'h00000081);
        fork
            tx_send(8'hFF, 1'b0);
            begin
                repeat (13) @(negedge clk);
                drive_bits(mk_frame(8'h81, 1'b1));
            end
        join

`ifdef UART_PARITY_EN
        // Flipped parity bit: error, no write, data kept.
        exp_err_q.push_back(32'h00000081);
        drive_bits({1'b1, ~(^8'h5A), 8'h5A, 1'b0});
`endif

        repeat (200) @(negedge clk);
        check("final_wr_count", n_wr_seen, 32'd2);
        check("final_err_count", n_err_seen, 32'(1 + NPAR));
        check("final_clr_count", n_clr_seen, 32'd2);
        check("pending_rx", exp_rx_q.size(), 32'd0);
        check("pending_err", exp_err_q.size(), 32'd0);
        check("pending_clr", exp_clr_q.size(), 32'd0);
        check("pending_tx", exp_tx_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
